pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline hazard, flush and multi-cycle mult/div stall controller
module pipeline_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_uses_rt_i,
  input  logic        id_jump_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rt_i,
  input  logic        ex_mdu_i,
  input  logic        mem_branch_taken_i,
  input  logic        mdu_done_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        idex_write_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic        mdu_start_o,
  output logic        mdu_abort_o,
  output logic        mdu_timeout_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [5:0]  WAIT_LIMIT = 6'd63;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t     state;
  state_t     next_state;
  logic [5:0] wait_cnt;
  logic       wait_clr;
  logic       wait_inc;
  logic       timeout_set;
  logic       load_use;
  logic       any_flush;

  // Load-use hazard: lw in EX writes a register the ID instruction reads; $0 never hazards.
  assign load_use = ex_memread_i && (ex_rt_i != 5'd0) &&
                    ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

  assign any_flush = ifid_flush_o || idex_flush_o || exmem_flush_o;

  // State register; reset always lands in RUN, even from MDU_WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Next state and pipeline controls; priority in RUN is branch > mult/div > load-use > jump.
  always_comb begin
    next_state    = state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mdu_start_o   = 1'b0;
    mdu_abort_o   = 1'b0;
    wait_clr      = 1'b0;
    wait_inc      = 1'b0;
    timeout_set   = 1'b0;
    if (!rst_i) begin
      unique case (state)
        RUN: begin
          if (mem_branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
          end else if (ex_mdu_i) begin
            mdu_start_o   = 1'b1;
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_flush_o = 1'b1;
            wait_clr      = 1'b1;
            next_state    = MDU_WAIT;
          end else if (load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_flush_o  = 1'b1;
          end else if (id_jump_i) begin
            ifid_flush_o  = 1'b1;
          end
        end
        MDU_WAIT: begin
          if (mdu_done_i) begin
            next_state    = RUN;
          end else if (wait_cnt == WAIT_LIMIT) begin
            // Watchdog expiry: kill the unit and let the pipeline move on.
            mdu_abort_o   = 1'b1;
            timeout_set   = 1'b1;
            next_state    = RUN;
          end else begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_flush_o = 1'b1;
            wait_inc      = 1'b1;
          end
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

  // Watchdog counter: cleared when the mult/div starts, counts each wait cycle without done.
  always_ff @(posedge clk_i) begin
    if (rst_i || wait_clr) begin
      wait_cnt <= 6'd0;
    end else if (wait_inc) begin
      wait_cnt <= wait_cnt + 6'd1;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mdu_timeout_o <= 1'b0;
    end else if (timeout_set) begin
      mdu_timeout_o <= 1'b1;
    end
  end

  // Saturating count of cycles where the PC was held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= 16'd0;
    end else if (!pc_write_o && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

  // Saturating count of cycles where any pipeline register took a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_cnt_o <= 16'd0;
    end else if (any_flush && (flush_cnt_o != CNT_MAX)) begin
      flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic        id_jump_i;
  logic        ex_memread_i;
  logic [4:0]  ex_rt_i;
  logic        ex_mdu_i;
  logic        mem_branch_taken_i;
  logic        mdu_done_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        idex_write_o;
  logic        ifid_flush_o;
  logic        idex_flush_o;
  logic        exmem_flush_o;
  logic        mdu_start_o;
  logic        mdu_abort_o;
  logic        mdu_timeout_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, start, abort}
  localparam logic [7:0] C_IDLE   = 8'hE0;
  localparam logic [7:0] C_BRANCH = 8'hFC;
  localparam logic [7:0] C_LOADU  = 8'h28;
  localparam logic [7:0] C_JUMP   = 8'hF0;
  localparam logic [7:0] C_START  = 8'h06;
  localparam logic [7:0] C_WAIT   = 8'h04;
  localparam logic [7:0] C_ABORT  = 8'hE1;

  logic [7:0] ctl;
  assign ctl = {pc_write_o, ifid_write_o, idex_write_o, ifid_flush_o,
                idex_flush_o, exmem_flush_o, mdu_start_o, mdu_abort_o};

  int n_cmp = 0;
  int n_err = 0;

  pipeline_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i), .id_jump_i(id_jump_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .ex_mdu_i(ex_mdu_i),
    .mem_branch_taken_i(mem_branch_taken_i), .mdu_done_i(mdu_done_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .idex_write_o(idex_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .mdu_start_o(mdu_start_o), .mdu_abort_o(mdu_abort_o), .mdu_timeout_o(mdu_timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clear_inputs;
    id_rs_i = 5'd0; id_rt_i = 5'd0; id_uses_rt_i = 1'b0; id_jump_i = 1'b0;
    ex_memread_i = 1'b0; ex_rt_i = 5'd0; ex_mdu_i = 1'b0;
    mem_branch_taken_i = 1'b0; mdu_done_i = 1'b0;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    clear_inputs();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    mem_branch_taken_i = 1'b1; ex_mdu_i = 1'b1; id_jump_i = 1'b1; mdu_done_i = 1'b1;
    ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL reset_ctl got %h exp %h", ctl, C_IDLE); end
    tick();
    n_cmp++;
    if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0 || mdu_timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs got stall=%0d flush=%0d to=%b exp 0 0 0", stall_cnt_o, flush_cnt_o, mdu_timeout_o);
    end
    rst_i = 1'b0;
    clear_inputs();
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL idle_ctl got %h exp %h", ctl, C_IDLE); end
  endtask

  task automatic test_load_use;
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
    settle();
    n_cmp++;
    if (ctl !== C_LOADU) begin n_err++; $display("FAIL lu_rs got %h exp %h", ctl, C_LOADU); end
    tick();
    clear_inputs();
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL lu_one_cycle got %h exp %h", ctl, C_IDLE); end
    n_cmp++;
    if (stall_cnt_o !== 16'd1 || flush_cnt_o !== 16'd1) begin
      n_err++;
      $display("FAIL lu_counts got stall=%0d flush=%0d exp 1 1", stall_cnt_o, flush_cnt_o);
    end
    ex_memread_i = 1'b1; ex_rt_i = 5'd9; id_rs_i = 5'd3; id_rt_i = 5'd9; id_uses_rt_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_LOADU) begin n_err++; $display("FAIL lu_rt got %h exp %h", ctl, C_LOADU); end
    tick();
  endtask

  task automatic test_no_stall;
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL ns_r0 got %h exp %h", ctl, C_IDLE); end
    tick();
    ex_rt_i = 5'd9; id_rs_i = 5'd3; id_rt_i = 5'd9; id_uses_rt_i = 1'b0;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL ns_rt_unused got %h exp %h", ctl, C_IDLE); end
    tick();
    n_cmp++;
    if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL ns_stall_cnt got %0d exp 0", stall_cnt_o); end
  endtask

  task automatic test_jump;
    do_reset();
    id_jump_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_JUMP) begin n_err++; $display("FAIL jump got %h exp %h", ctl, C_JUMP); end
    ex_memread_i = 1'b1; ex_rt_i = 5'd4; id_rs_i = 5'd4;
    settle();
    n_cmp++;
    if (ctl !== C_LOADU) begin n_err++; $display("FAIL jump_vs_lu got %h exp %h", ctl, C_LOADU); end
    tick();
  endtask

  task automatic test_branch;
    do_reset();
    mem_branch_taken_i = 1'b1; id_jump_i = 1'b1;
    ex_memread_i = 1'b1; ex_rt_i = 5'd8; id_rs_i = 5'd8;
    settle();
    n_cmp++;
    if (ctl !== C_BRANCH) begin n_err++; $display("FAIL branch got %h exp %h", ctl, C_BRANCH); end
    tick();
    clear_inputs();
    settle();
    n_cmp++;
    if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL branch_counts got flush=%0d stall=%0d exp 1 0", flush_cnt_o, stall_cnt_o);
    end
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL branch_after got %h exp %h", ctl, C_IDLE); end
  endtask

  task automatic test_mdu_done;
    do_reset();
    ex_mdu_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_START) begin n_err++; $display("FAIL mdu_start got %h exp %h", ctl, C_START); end
    tick();
    ex_mdu_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      mem_branch_taken_i = (k == 2);
      id_jump_i = (k == 3);
      settle();
      n_cmp++;
      if (ctl !== C_WAIT) begin n_err++; $display("FAIL mdu_wait%0d got %h exp %h", k, ctl, C_WAIT); end
      tick();
    end
    clear_inputs();
    mdu_done_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL mdu_done got %h exp %h", ctl, C_IDLE); end
    tick();
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL done_in_run got %h exp %h", ctl, C_IDLE); end
    n_cmp++;
    if (stall_cnt_o !== 16'd6 || flush_cnt_o !== 16'd6 || mdu_timeout_o !== 1'b0) begin
      n_err++;
      $display("FAIL mdu_counts got stall=%0d flush=%0d to=%b exp 6 6 0", stall_cnt_o, flush_cnt_o, mdu_timeout_o);
    end
    tick();
    mdu_done_i = 1'b0;
  endtask

  task automatic test_mdu_timeout;
    do_reset();
    ex_mdu_i = 1'b1;
    tick();
    ex_mdu_i = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      settle();
      n_cmp++;
      if (ctl !== C_WAIT) begin n_err++; $display("FAIL to_wait%0d got %h exp %h", k, ctl, C_WAIT); end
      tick();
    end
    settle();
    n_cmp++;
    if (ctl !== C_ABORT) begin n_err++; $display("FAIL to_abort got %h exp %h", ctl, C_ABORT); end
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++;
      if (ctl !== C_IDLE || mdu_timeout_o !== 1'b1) begin
        n_err++;
        $display("FAIL to_sticky%0d got ctl=%h to=%b exp %h 1", k, ctl, mdu_timeout_o, C_IDLE);
      end
      tick();
    end
    n_cmp++;
    if (stall_cnt_o !== 16'd64) begin n_err++; $display("FAIL to_stall_cnt got %0d exp 64", stall_cnt_o); end
    do_reset();
    n_cmp++;
    if (mdu_timeout_o !== 1'b0) begin n_err++; $display("FAIL to_cleared got %b exp 0", mdu_timeout_o); end
  endtask

  task automatic test_done_beats_timeout;
    do_reset();
    ex_mdu_i = 1'b1;
    tick();
    ex_mdu_i = 1'b0;
    for (int k = 1; k <= 63; k++) tick();
    mdu_done_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL done_prio got %h exp %h", ctl, C_IDLE); end
    tick();
    mdu_done_i = 1'b0;
    n_cmp++;
    if (mdu_timeout_o !== 1'b0) begin n_err++; $display("FAIL done_prio_to got %b exp 0", mdu_timeout_o); end
  endtask

  task automatic test_reset_in_wait;
    do_reset();
    ex_mdu_i = 1'b1;
    tick();
    ex_mdu_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE) begin n_err++; $display("FAIL rw_during got %h exp %h", ctl, C_IDLE); end
    tick();
    rst_i = 1'b0;
    settle();
    n_cmp++;
    if (ctl !== C_IDLE || stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
      n_err++;
      $display("FAIL rw_after got ctl=%h stall=%0d flush=%0d exp %h 0 0", ctl, stall_cnt_o, flush_cnt_o, C_IDLE);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    tick();
    test_reset();
    test_load_use();
    test_no_stall();
    test_jump();
    test_branch();
    test_mdu_done();
    test_mdu_timeout();
    test_done_beats_timeout();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
